// File: rtl/mini_cpu_pkg.sv
// Shared definitions for the mini CPU datapath: opcodes, FSM encoding
// and the flag bit positions of the display word.
package mini_cpu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam int DISP_MUL_BIT = 8;
    localparam int DISP_DIV_BIT = 9;

    typedef enum logic {
        S_IDLE,
        S_EXEC
    } state_t;

endpackage

// File: rtl/seq_muldiv.sv
// Iterative shift-add multiplier / restoring divider sharing one register set.
// Outputs are the post-step values so the caller can capture on the last step.
module seq_muldiv
    import mini_cpu_pkg::*;
#(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           step,
    input  logic           is_div,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] product,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder
);

    // acc: product / partial remainder; sh: multiplicand / dividend-quotient
    logic [2*W-1:0] acc, acc_n;
    logic [2*W-1:0] sh, sh_n;
    logic [W-1:0]   bq, bq_n;
    logic [W:0]     r_sh;
    logic [W-1:0]   rsub;
    logic           ge;

    always_comb begin
        acc_n = acc;
        sh_n  = sh;
        bq_n  = bq;
        r_sh  = '0;
        rsub  = '0;
        ge    = 1'b0;
        if (is_div) begin
            r_sh  = {acc[W-1:0], sh[W-1]};
            ge    = (r_sh >= {1'b0, bq});
            rsub  = r_sh[W-1:0] - bq;
            acc_n = {W'(0), (ge ? rsub : r_sh[W-1:0])};
            sh_n  = {W'(0), sh[W-2:0], ge};
        end else begin
            acc_n = acc + (bq[0] ? sh : '0);
            sh_n  = sh << 1;
            bq_n  = bq >> 1;
        end
    end

    assign product   = acc_n;
    assign quotient  = sh_n[W-1:0];
    assign remainder = acc_n[W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            sh  <= '0;
            bq  <= '0;
        end else if (load) begin
            acc <= '0;
            sh  <= {W'(0), a};
            bq  <= b;
        end else if (step) begin
            acc <= acc_n;
            sh  <= sh_n;
            bq  <= bq_n;
        end
    end

endmodule

// File: rtl/mini_alu_sequencer.sv
// Multi-cycle ALU feeding the two-digit hex display; ADD/SUB finish in one
// cycle, MUL/DIV iterate W cycles in seq_muldiv.
module mini_alu_sequencer
    import mini_cpu_pkg::*;
#(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [1:0]     op,
    input  logic [W-1:0]   operand_a,
    input  logic [W-1:0]   operand_b,
    output logic [2*W+1:0] disp_word,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam int CW = $clog2(W + 1);

    state_t         state_q, state_d;
    logic [1:0]     op_q;
    logic [W-1:0]   a_q, b_q;
    logic           dz_q;
    logic [CW-1:0]  cnt_q;
    logic [2*W+1:0] disp_q, res;
    logic           done_q, err_q;
    logic           accept, step, fin;
    logic           div_zero, iter;
    logic [2*W-1:0] product;
    logic [W-1:0]   quotient, remainder;

    assign div_zero = (op == OP_DIV) && (operand_b == '0);
    assign iter     = op[1] && !div_zero;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        fin     = 1'b0;
        res     = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                unique case (1'b1)
                    dz_q: begin
                        fin               = 1'b1;
                        res[2*W-1:0]      = '1;
                        res[DISP_DIV_BIT] = 1'b1;
                    end
                    (op_q == OP_ADD): begin
                        fin          = 1'b1;
                        res[2*W-1:0] = {W'(0), a_q} + {W'(0), b_q};
                    end
                    (op_q == OP_SUB): begin
                        fin          = 1'b1;
                        res[2*W-1:0] = {W'(0), a_q} - {W'(0), b_q};
                    end
                    default: begin
                        step = 1'b1;
                        fin  = (cnt_q == CW'(1));
                        if (op_q == OP_MUL) begin
                            res[2*W-1:0]      = product;
                            res[DISP_MUL_BIT] = 1'b1;
                        end else begin
                            res[2*W-1:0]      = {quotient, remainder};
                            res[DISP_DIV_BIT] = 1'b1;
                        end
                    end
                endcase
                if (fin) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= OP_ADD;
            a_q    <= '0;
            b_q    <= '0;
            dz_q   <= 1'b0;
            cnt_q  <= '0;
            disp_q <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= fin;
            if (accept) begin
                op_q  <= op;
                a_q   <= operand_a;
                b_q   <= operand_b;
                dz_q  <= div_zero;
                err_q <= 1'b0;
                cnt_q <= iter ? CW'(W) : '0;
            end else if (step) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (fin) begin
                disp_q <= res;
                if (dz_q) err_q <= 1'b1;
            end
        end
    end

    seq_muldiv #(.W(W)) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .step      (step),
        .is_div    (op_q == OP_DIV),
        .a         (operand_a),
        .b         (operand_b),
        .product   (product),
        .quotient  (quotient),
        .remainder (remainder)
    );

    assign disp_word = disp_q;
    assign busy      = (state_q == S_EXEC);
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mini_alu_sequencer.sv
// Directed bench for mini_alu_sequencer: hand-computed display words,
// latencies and handshake corner cases.
module tb_mini_alu_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] op;
    logic [3:0] operand_a;
    logic [3:0] operand_b;
    logic [9:0] disp_word;
    logic       busy;
    logic       done;
    logic       err;

    int passed = 0;
    int total  = 0;

    mini_alu_sequencer #(.W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .disp_word (disp_word),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Pulse start for one edge; returns 1ns after the accepting edge.
    task automatic start_op(input logic [1:0] o, input logic [3:0] x,
                            input logic [3:0] y);
        @(negedge clk);
        op        = o;
        operand_a = x;
        operand_b = y;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Cycles until done (bounded); counts busy samples seen before done.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = -1;
        bcnt = busy ? 1 : 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
            if (busy) bcnt = bcnt + 1;
        end
    endtask

    int lat, bcnt;
    int seen_done;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op = 2'b00;
        operand_a = '0;
        operand_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_disp", disp_word, 10'h000);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD with carry into bit 4
        start_op(2'b00, 4'hF, 4'h1);
        chk("add_busy", busy, 1);
        wait_done(lat, bcnt);
        chk("add_lat", lat, 1);
        chk("add_disp", disp_word, 10'h010);
        chk("add_idle", busy, 0);

        // SUB wraps to 8-bit two's complement
        start_op(2'b01, 4'd3, 4'd5);
        wait_done(lat, bcnt);
        chk("sub_lat", lat, 1);
        chk("sub_disp", disp_word, 10'h0FE);

        // MUL max operands
        start_op(2'b10, 4'hF, 4'hF);
        wait_done(lat, bcnt);
        chk("mul_lat", lat, 4);
        chk("mul_busy_cycles", bcnt, 4);
        chk("mul_disp", disp_word, 10'h1E1);
        @(posedge clk);
        #1;
        chk("mul_done_width", done, 0);
        chk("mul_disp_hold", disp_word, 10'h1E1);

        // DIV 13/4 -> q=3 r=1
        start_op(2'b11, 4'd13, 4'd4);
        wait_done(lat, bcnt);
        chk("div_lat", lat, 4);
        chk("div_disp", disp_word, 10'h231);
        chk("div_err", err, 0);

        // DIV by zero
        start_op(2'b11, 4'd7, 4'd0);
        wait_done(lat, bcnt);
        chk("div0_lat", lat, 1);
        chk("div0_disp", disp_word, 10'h2FF);
        chk("div0_err", err, 1);

        // next accepted start clears err
        start_op(2'b00, 4'd2, 4'd3);
        chk("add_clr_err", err, 0);
        wait_done(lat, bcnt);
        chk("add2_disp", disp_word, 10'h005);

        // start mid-MUL is ignored
        start_op(2'b10, 4'd3, 4'd5);
        start_op(2'b00, 4'd1, 4'd1);
        chk("repulse_err", err, 0);
        wait_done(lat, bcnt);
        chk("repulse_lat", lat, 3);
        chk("repulse_disp", disp_word, 10'h10F);

        // start in the done cycle is accepted
        start_op(2'b00, 4'd1, 4'd2);
        wait_done(lat, bcnt);
        chk("b2b_first", disp_word, 10'h003);
        start_op(2'b10, 4'd2, 4'd3);
        chk("b2b_busy", busy, 1);
        chk("b2b_hold", disp_word, 10'h003);
        wait_done(lat, bcnt);
        chk("b2b_lat", lat, 4);
        chk("b2b_disp", disp_word, 10'h106);

        // reset in the 2nd EXEC cycle of a DIV
        start_op(2'b11, 4'd9, 4'd2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_disp", disp_word, 10'h000);
        chk("mid_rst_done", done, 0);
        seen_done = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1;
        end
        chk("mid_rst_no_done", seen_done, 0);
        chk("mid_rst_idle_disp", disp_word, 10'h000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
